// File: rtl/isram_pkg.sv
// Shared types and helpers for the instruction-SRAM responder: arbitration
// states, default geometry and the address range check.
package isram_pkg;

  localparam int DEPTH_LOG2_DEF = 12;
  localparam int STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_LDWAIT  = 2'd1,
    ST_LDGRANT = 2'd2
  } isram_state_e;

  // True when a byte address falls inside a 2^depth_log2 doubleword array.
  function automatic logic addr_in_range(input logic [31:0] byte_addr,
                                         input int depth_log2);
    return (byte_addr >> (depth_log2 + 3)) == 32'd0;
  endfunction

endpackage

// File: rtl/isram_array.sv
// Single-port 64-bit synchronous RAM with per-byte write mask. Reads are
// registered and the read register only updates on a read access.
module isram_array #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [7:0]            be,
  input  logic [63:0]           wdata,
  output logic [63:0]           rdata
);

  logic [63:0] mem_q [2**DEPTH_LOG2];
  logic [63:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 8; i++) begin
          if (be[i]) mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/isram_resp.sv
// Instruction-SRAM responder: serves 64-bit fetches with one cycle latency and
// arbitrates a 32-bit loader port into the same array with bounded starvation.
module isram_resp
  import isram_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic        clk,
  input  logic        cpurst,
  input  logic        isram_cs,
  input  logic [28:0] isram_adr,
  output logic [63:0] instr_fromsram,
  output logic        isram_err,
  output logic        isram_stall,
  input  logic        ld_valid,
  input  logic        ld_we,
  input  logic [29:0] ld_addr,
  input  logic [3:0]  ld_be,
  input  logic [31:0] ld_wdata,
  output logic        ld_ready,
  output logic        ld_rvalid,
  output logic [31:0] ld_rdata,
  output logic [1:0]  dbg_state
);

  localparam int CW = $clog2(STARVE_MAX) + 1;

  // Loader handshake: a request is accepted in any cycle where
  // ld_valid && ld_ready; fields must stay stable until then.
  isram_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rdy_raw, stall_raw;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdy_raw   = 1'b0;
    stall_raw = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (ld_valid) begin
          if (!isram_cs) begin
            rdy_raw = 1'b1;
          end else begin
            state_d = ST_LDWAIT;
            cnt_d   = '0;
          end
        end
      end
      ST_LDWAIT: begin
        if (!ld_valid) begin
          state_d = ST_FETCH;
        end else begin
          if (isram_cs) cnt_d = cnt_q + 1'b1;
          if (!isram_cs || cnt_d >= CW'(STARVE_MAX - 1)) state_d = ST_LDGRANT;
        end
      end
      ST_LDGRANT: begin
        rdy_raw   = 1'b1;
        stall_raw = isram_cs;
        state_d   = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Handshake outputs are forced low while reset is held.
  assign ld_ready    = rdy_raw & cpurst;
  assign isram_stall = stall_raw & cpurst;
  assign dbg_state   = state_q;

  logic ld_acc, fetch_go, fetch_ok, ld_ok;
  assign ld_acc   = ld_ready & ld_valid;
  assign fetch_go = isram_cs & ~isram_stall & cpurst;
  assign fetch_ok = addr_in_range({isram_adr, 3'b000}, DEPTH_LOG2);
  assign ld_ok    = addr_in_range({ld_addr, 2'b00}, DEPTH_LOG2);

  logic                  arr_en, arr_we;
  logic [DEPTH_LOG2-1:0] arr_addr;
  logic [7:0]            arr_be;
  logic [63:0]           arr_wdata, arr_rdata;

  // A loader access only happens when fetch is idle or stalled, so the
  // single port never sees both in one cycle.
  assign arr_en    = ld_acc ? ld_ok : (fetch_go & fetch_ok);
  assign arr_we    = ld_acc & ld_we;
  assign arr_addr  = ld_acc ? ld_addr[DEPTH_LOG2:1] : isram_adr[DEPTH_LOG2-1:0];
  assign arr_be    = ld_addr[0] ? {ld_be, 4'h0} : {4'h0, ld_be};
  assign arr_wdata = {ld_wdata, ld_wdata};

  isram_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (arr_we),
    .addr  (arr_addr),
    .be    (arr_be),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  logic        fvld_q, fvld_d;
  logic        ferr_q, ferr_d;
  logic [63:0] instr_hold_q, instr_hold_d;
  logic        rvalid_q, rvalid_d;
  logic        rd_ok_q, rd_ok_d;
  logic        rd_hi_q, rd_hi_d;

  // The array read register is shared with loader reads, so the last fetch
  // result is kept separately to hold across idle and stalled cycles.
  assign instr_fromsram = fvld_q ? (ferr_q ? 64'd0 : arr_rdata) : instr_hold_q;
  assign isram_err      = ferr_q;
  assign ld_rvalid      = rvalid_q;
  assign ld_rdata       = (rvalid_q & rd_ok_q) ?
                          (rd_hi_q ? arr_rdata[63:32] : arr_rdata[31:0]) : 32'd0;

  always_comb begin
    fvld_d       = fetch_go;
    ferr_d       = fetch_go ? ~fetch_ok : ferr_q;
    instr_hold_d = instr_fromsram;
    rvalid_d     = ld_acc & ~ld_we;
    rd_ok_d      = ld_acc ? ld_ok : rd_ok_q;
    rd_hi_d      = ld_acc ? ld_addr[0] : rd_hi_q;
  end

  always_ff @(posedge clk or negedge cpurst) begin
    if (!cpurst) begin
      state_q      <= ST_FETCH;
      cnt_q        <= '0;
      fvld_q       <= 1'b0;
      ferr_q       <= 1'b0;
      instr_hold_q <= 64'd0;
      rvalid_q     <= 1'b0;
      rd_ok_q      <= 1'b0;
      rd_hi_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fvld_q       <= fvld_d;
      ferr_q       <= ferr_d;
      instr_hold_q <= instr_hold_d;
      rvalid_q     <= rvalid_d;
      rd_ok_q      <= rd_ok_d;
      rd_hi_q      <= rd_hi_d;
    end
  end

endmodule

// File: doc/isram_resp.md
# isram_resp

Responder end of the instruction-SRAM fetch interface. Owns a single-port 64-bit instruction memory. Returns one registered 64-bit doubleword per fetch request. Also arbitrates a 32-bit loader/debug port, used for program load and readback, into the same array. Sits between the fetch stage, which drives `isram_cs`/`isram_adr` and consumes the doubleword, and the SoC loader; `isram_stall` feeds the core's fetch-stall logic.

## Interface
- `DEPTH_LOG2`, default 12: array holds 2^DEPTH_LOG2 64-bit doublewords.
- `STARVE_MAX`, default 4: maximum consecutive cycles a pending loader request waits behind fetch.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `cpurst`  in  1  reset; asynchronous, active-low.
- `isram_cs`  in  1  fetch read request this cycle.
- `isram_adr`  in  29  doubleword address [31:3].
- `instr_fromsram`  out  64  read data, registered.
- `isram_err`  out  1  registered with data; previous read was out of range.
- `isram_stall`  out  1  combinational; fetch request this cycle is not serviced.
- `ld_valid`  in  1  loader request.
- `ld_we`  in  1  1 = write, 0 = read.
- `ld_addr`  in  30  word address [31:2].
- `ld_be`  in  4  byte enables for the write.
- `ld_wdata`  in  32  write data.
- `ld_ready`  out  1  combinational; request accepted this cycle.
- `ld_rvalid`  out  1  one-cycle pulse; read data valid.
- `ld_rdata`  out  32  read data.

## Operation
- FSM states:
  - FETCH: normal state; fetch owns the array.
  - LDWAIT: loader pending, fetch still owns the array.
  - LDGRANT: loader owns the array for one cycle.
- FETCH transitions:
  - `ld_valid` with `isram_cs`=0: grant immediately. Stay in FETCH, assert `ld_ready`.
  - `ld_valid` with `isram_cs`=1: go to LDWAIT and clear the starve counter.
- LDWAIT:
  - Starve counter increments each cycle that `isram_cs`=1.
  - Moves to LDGRANT when `isram_cs`=0, or when the counter reaches STARVE_MAX-1.
  - If `ld_valid` drops, return to FETCH. Loader must hold request fields stable while `ld_valid`=1 and `ld_ready`=0.
- LDGRANT:
  - `ld_ready`=1.
  - `isram_stall`=`isram_cs`.
  - Return to FETCH next cycle.
- Fetch read (`isram_cs`=1, not stalled): array word `isram_adr[DEPTH_LOG2+2:3]` appears on `instr_fromsram` the next cycle.
  - Upper address bits nonzero: data = 0 and `isram_err`=1 next cycle.
- `instr_fromsram`/`isram_err` hold their last value in any cycle with no serviced fetch, including stalled cycles. Fetch relies on this during its own stalls.
- Loader write: `ld_addr[2]` selects the upper (1) or lower (0) 32-bit half; `ld_be` masks bytes. Out-of-range writes are dropped silently.
- Loader read: `ld_rdata` = selected half, `ld_rvalid`=1 the cycle after accept. Out-of-range reads return 0.
- A loader write followed by a fetch of the same address on the next cycle returns the new data. No bypass is needed because the write completes at the accept edge.

## Timing
- Fetch read latency: 1 cycle.
- Loader: accept edge, then data/pulse 1 cycle later. Maximum loader wait is STARVE_MAX cycles under continuous fetch.
- Reset values: `instr_fromsram`=0, `isram_err`=0, `ld_rvalid`=0, `ld_rdata`=0, FSM=FETCH, counter=0. `isram_stall`/`ld_ready` are 0 during reset. The array is not reset.
- Reset asserted mid-grant: the write may or may not land; the FSM returns to FETCH and no `ld_rvalid` is issued.
- Simultaneous `isram_cs` and `ld_valid` in FETCH: fetch wins that cycle.

## Structure
- Package `isram_pkg`: FSM state enum, default DEPTH_LOG2/STARVE_MAX constants, address-range check function.
- One sub-module, `isram_array`: single-port 64-bit synchronous RAM with 8-bit byte-write mask, registered read. The top maps `ld_be`/`ld_addr[2]` onto the 8-bit mask.

## Test plan
- After reset, drive `isram_cs`=1, adr=0 with mem[0]=64'h0000_0013_0000_0093 → `instr_fromsram` equals that value one cycle later, `isram_err`=0.
- Loader write addr 0x4>>2 (word 1), be=4'hF, data 32'hDEADBEEF, then fetch adr 0 → upper half = DEADBEEF and lower half unchanged.
- Continuous `isram_cs`=1 with `ld_valid` held → `ld_ready` and `isram_stall` rise together on the 4th wait cycle; `instr_fromsram` holds its previous value across the stall.
- Fetch adr = 1<<DEPTH_LOG2 → data 0, `isram_err`=1 next cycle. Loader read of the same region → `ld_rdata`=0, `ld_rvalid` pulse.
- Byte write be=4'b0010, data 32'hxxxx_AAxx to word 0 of 32'h11223344 → loader readback 32'h1122AA44.
- Drive `cpurst` low during LDGRANT → FSM=FETCH, `ld_rvalid`=0, outputs 0 while reset is held low.
